fsk_tone_generator: RTL and testbench
=====================================

# fsk_tone_generator

Single-clock FSK/OOK tone source for the modulator datapath. Two programmable tick dividers set a high tone and a low tone. A message serializer shifts a 5-bit word out on the high-tone tick. A sine DDS advances on the tick chosen by the current message bit. The registered 8-bit sample output feeds the downstream PWM DAC.

## Interface
Parameters:
- `MSG_W`, default 5: message width.
- `BIT_TICKS`, default 256: high-tone ticks per message bit; must be ≥1.

Ports:
- `clk`, in, 1: sole clock; every register is clocked on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `init`, in, 1: synchronous reload of both dividers.
- `PL`, in, 3: pitch level.
- `send`, in, 1: start request; rising edge only.
- `Msg`, in, `MSG_W`: message word.
- `Mode`, in, 1: 1 = FSK, 0 = OOK.
- `magnitude`, out, 8: registered DDS sample.
- `msg_bit`, out, 1: current serialized bit.
- `busy`, out, 1: transmission in progress.
- `co_h`, `co_l`, out, 1 each: high-tone and low-tone tick pulses.

## Operation
- **High divider:** 8-bit counter `cnt_h`, load value `LH = {PL,5'b0}`.
  - `co_h = (cnt_h == 8'hFF)`, combinational.
  - When `cnt_h == 8'hFF`, the counter reloads `LH`; otherwise it increments.
  - Tick period = 256 − 32·PL cycles: 256 at PL=0, 32 at PL=7.
- **Low divider:** identical with a 9-bit counter and `LL = {PL,6'b0}`.
  - Tick period = 512 − 64·PL cycles, always exactly twice the high period.
- **`init` high:** both counters load their current load value; `co_h` and `co_l` are 0 while `cnt` is not max. Changing `PL` takes effect at the next reload or `init`.
- **Serializer:**
  - `send_q` registers `send`. A start condition is `send & ~send_q & ~busy`.
  - On start: latch `Msg`, set `busy`, drive `msg_bit = Msg[MSG_W-1]` (MSB first).
  - A tick counter counts `co_h` pulses. After `BIT_TICKS` pulses it shifts to the next bit.
  - After the LSB's `BIT_TICKS` pulses, `busy` and `msg_bit` return to 0.
  - A `send` edge while busy is ignored. A held `send` does not retrigger.
- **DDS:**
  - 8-bit phase register; `tick = msg_bit ? co_l : co_h`. The phase increments on `tick` and wraps 255→0.
  - Phase is continuous and is never reset at bit boundaries.
  - The phase advances in both modes and while idle.
  - Sine table: `lut[k] = 128 + round(127·sin(2πk/256))`, so `lut[0] = 128`, `lut[64] = 255`, `lut[128] = 128`, `lut[192] = 1`.
- **Output register:** each cycle, `magnitude <= (Mode | msg_bit) ? lut[phase] : 8'h80`.
  - Net effect: bit 1 gives the low tone.
  - Bit 0 gives the high tone in FSK mode and midscale (0x80) in OOK mode.

## Timing
- **Reset values:**
  - Counters = their load values; phase = 0.
  - `magnitude = 8'h80`; `msg_bit = 0`; `busy = 0`; `send_q = 0`.
  - `co_h = co_l = 0`, except at PL where load = max (not reachable).
- **First tick after reset release:** `co_h` asserts at cycle 255 − LH, counting the first post-reset cycle as 0.
- **Start latency:** if an edge is detected at cycle t, `busy` and `msg_bit` are valid at t+1.
- **Bit advance:** occurs in the cycle after the `BIT_TICKS`-th `co_h` pulse.
- **Frame length:** one frame = `MSG_W·BIT_TICKS` high ticks, plus an alignment slip of less than one period.
- **Sample latency:** `magnitude` lags `phase`/`msg_bit` by one cycle.
- **Simultaneous events:** `rst` dominates `init`, which dominates counting. `init` mid-frame does not abort the frame; it only re-phases the ticks.
- **`rst` mid-frame:** immediate return to idle.

## Configuration
- Macro `FSKGEN_QUARTER_WAVE_EN`, when defined, selects a 65-entry quarter-wave table (k = 0..64) with symmetry reconstruction:
  - `lut[64+j] = q[64−j]`
  - `lut[128+j] = 256 − lut[j]`
- When undefined, a full 256-entry table is used.
- Output values must be bit-identical in both builds.

## Structure
- A shared package `fskgen_pkg` holds:
  - `PHASE_W = 8`, `MID = 8'h80`.
  - The divider widths (8 and 9).
  - The sine table function/constant.
- One sub-module, `tick_divider` (parameter `W`, inputs `load_val`/`init`), is instantiated twice. The serializer and DDS are inline.

## Test plan
- **Reset:** assert `rst` for 3 cycles → `magnitude = 0x80`, `busy = 0`, `msg_bit = 0`, phase 0.
- **Divider periods:** PL=0 → `co_h` every 256 cycles, `co_l` every 512; PL=7 → 32 and 64; `init` pulse mid-count → next `co_h` exactly 256−LH cycles later.
- **FSK frame:** `BIT_TICKS = 4`, PL=7, `Mode = 1`, `Msg = 5'b10110`, pulse `send` → `msg_bit` = 1,0,1,1,0, each for 128 cycles (4·32); `busy` high about 640 cycles, then 0.
- **OOK mode:** `Mode = 0`, `Msg = 5'b01000` → `magnitude` = 0x80 except during bit 3, when it tracks `lut[phase]` advancing every `co_l`.
- **Table points:** idle, `Mode = 1`, PL=7 → after 64 `co_h` ticks `magnitude = 255`, after 192 ticks `magnitude = 1`, after 256 ticks `magnitude = 128`. Repeat with `FSKGEN_QUARTER_WAVE_EN` defined → identical trace.
- **Ignored requests:** `send` re-pulsed or held high during a frame → no restart, and no new frame after `busy` falls until a fresh rising edge.

Source files
------------

// File: rtl/fskgen_pkg.sv
// Shared constants, serializer state type and sine table for fsk_tone_generator.
// The table is stored as a quarter wave; full-wave lookup rebuilds it by symmetry.
package fskgen_pkg;

    localparam int PHASE_W = 8;
    localparam logic [7:0] MID = 8'h80;
    localparam int DIVH_W = 8;
    localparam int DIVL_W = 9;
    localparam int QW_N = 65;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } ser_state_e;

    // 128 + round(127*sin(2*pi*k/256)) for k = 0..64
    localparam logic [7:0] QW [QW_N] = '{
        8'd128, 8'd131, 8'd134, 8'd137, 8'd140,
        8'd144, 8'd147, 8'd150, 8'd153, 8'd156,
        8'd159, 8'd162, 8'd165, 8'd168, 8'd171,
        8'd174, 8'd177, 8'd179, 8'd182, 8'd185,
        8'd188, 8'd191, 8'd193, 8'd196, 8'd199,
        8'd201, 8'd204, 8'd206, 8'd209, 8'd211,
        8'd213, 8'd216, 8'd218, 8'd220, 8'd222,
        8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
        8'd234, 8'd235, 8'd237, 8'd239, 8'd240,
        8'd241, 8'd243, 8'd244, 8'd245, 8'd246,
        8'd248, 8'd249, 8'd250, 8'd250, 8'd251,
        8'd252, 8'd253, 8'd253, 8'd254, 8'd254,
        8'd254, 8'd255, 8'd255, 8'd255, 8'd255
    };

    function automatic logic [7:0] sine_lut(
        input logic [PHASE_W-1:0] k
    );
        logic [6:0] idx;
        logic [7:0] v;
        if (k[6])
            idx = 7'(7'd64 - {1'b0, k[5:0]});
        else
            idx = {1'b0, k[5:0]};
        v = QW[idx];
        // second half is the first half mirrored about midscale
        if (k[7])
            v = 8'(9'd256 - {1'b0, v});
        return v;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running reloadable tick divider: counts from load_val up to all-ones.
// co pulses for one cycle at all-ones; period is 2**W - load_val cycles.
module tick_divider
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic [W-1:0] load_val,
    output logic         co
);
    import fskgen_pkg::*;

    logic [W-1:0] cnt;

    assign co = &cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= load_val;
        else if (init || co)
            cnt <= load_val;
        else
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/fsk_tone_generator.sv
// FSK/OOK tone source: two tick dividers, MSB-first serializer and sine DDS.
// Define FSKGEN_QUARTER_WAVE_EN to use the folded quarter-wave sine lookup.
module fsk_tone_generator
#(
    parameter int MSG_W     = 5,
    parameter int BIT_TICKS = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [2:0]       PL,
    input  logic             send,
    input  logic [MSG_W-1:0] Msg,
    input  logic             Mode,
    output logic [7:0]       magnitude,
    output logic             msg_bit,
    output logic             busy,
    output logic             co_h,
    output logic             co_l
);
    import fskgen_pkg::*;

    localparam int TW = $clog2(BIT_TICKS + 1);
    localparam int BW = $clog2(MSG_W + 1);

    logic [DIVH_W-1:0] load_h;
    logic [DIVL_W-1:0] load_l;

    assign load_h = {PL, 5'b0};
    assign load_l = {PL, 6'b0};

    tick_divider #(.W(DIVH_W)) u_div_h (
        .clk      (clk),
        .rst      (rst),
        .init     (init),
        .load_val (load_h),
        .co       (co_h)
    );

    tick_divider #(.W(DIVL_W)) u_div_l (
        .clk      (clk),
        .rst      (rst),
        .init     (init),
        .load_val (load_l),
        .co       (co_l)
    );

    ser_state_e       state_q, state_d;
    logic [MSG_W-1:0] sr_q, sr_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [TW-1:0]    tk_q, tk_d;
    logic             send_q;
    logic             start;

    assign busy    = (state_q == S_SEND);
    assign msg_bit = busy & sr_q[MSG_W-1];
    assign start   = send & ~send_q & ~busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            tk_q    <= '0;
            send_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            tk_q    <= tk_d;
            send_q  <= send;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        tk_d    = tk_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEND;
                    sr_d    = Msg;
                    bit_d   = '0;
                    tk_d    = '0;
                end
            end
            S_SEND: begin
                if (co_h) begin
                    if (tk_q == TW'(BIT_TICKS - 1)) begin
                        tk_d = '0;
                        if (bit_q == BW'(MSG_W - 1)) begin
                            state_d = S_IDLE;
                            sr_d    = '0;
                        end else begin
                            sr_d  = sr_q << 1;
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tk_d = tk_q + TW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // phase never resets on bit boundaries, so tone switches are phase-continuous
    logic [PHASE_W-1:0] phase_q;
    logic               dds_tick;
    logic [7:0]         sample;

    assign dds_tick = msg_bit ? co_l : co_h;

    always_ff @(posedge clk) begin
        if (rst)
            phase_q <= '0;
        else
            phase_q <= phase_q + PHASE_W'(dds_tick);
    end

`ifdef FSKGEN_QUARTER_WAVE_EN
    assign sample = sine_lut(phase_q);
`else
    logic [7:0] full_lut [256];

    for (genvar k = 0; k < 256; k++) begin : g_lut
        assign full_lut[k] = sine_lut(PHASE_W'(k));
    end

    assign sample = full_lut[phase_q];
`endif

    always_ff @(posedge clk) begin
        if (rst)
            magnitude <= MID;
        else
            magnitude <= (Mode | msg_bit) ? sample : MID;
    end

endmodule

// File: tb/tb_fsk_tone_generator.sv
// Self-checking bench for fsk_tone_generator: per-cycle reference model
// plus directed checks of divider periods, frames, table points and resets.
module tb_fsk_tone_generator;

    localparam int MSG_W = 5;
    localparam int BT    = 4;

    logic             clk = 1'b0;
    logic             rst, init, send, Mode;
    logic [2:0]       PL;
    logic [MSG_W-1:0] Msg;
    logic [7:0]       magnitude;
    logic             msg_bit, busy, co_h, co_l;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fsk_tone_generator #(.MSG_W(MSG_W), .BIT_TICKS(BT)) dut (
        .clk       (clk),
        .rst       (rst),
        .init      (init),
        .PL        (PL),
        .send      (send),
        .Msg       (Msg),
        .Mode      (Mode),
        .magnitude (magnitude),
        .msg_bit   (msg_bit),
        .busy      (busy),
        .co_h      (co_h),
        .co_l      (co_l)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sine_ref(input int k);
        real x;
        x = 127.0 * $sin(6.283185307179586 * k / 256.0);
        if (x >= 0.0)
            return 128 + $rtoi(x + 0.5);
        return 128 - $rtoi(-x + 0.5);
    endfunction

    // reference model: cycles since last divider load, frame as word + index
    int               age_h, age_l, m_pl, m_phase, m_idx, m_ticks, m_mag;
    bit               m_busy, m_sendq;
    logic [MSG_W-1:0] m_word;

    function automatic bit exp_ch();
        return (age_h % (256 - 32 * m_pl)) == (255 - 32 * m_pl);
    endfunction

    function automatic bit exp_cl();
        return (age_l % (512 - 64 * m_pl)) == (511 - 64 * m_pl);
    endfunction

    function automatic bit exp_mb();
        return m_busy ? m_word[MSG_W-1-m_idx] : 1'b0;
    endfunction

    always @(posedge clk) begin : model
        bit ch, cl, mb;
        ch = exp_ch();
        cl = exp_cl();
        mb = exp_mb();
        if (rst) begin
            age_h = 0; age_l = 0; m_pl = int'(PL);
            m_busy = 0; m_idx = 0; m_ticks = 0;
            m_phase = 0; m_mag = 128; m_sendq = 0;
        end else begin
            m_mag = (Mode || mb) ? sine_ref(m_phase) : 128;
            if (mb ? cl : ch)
                m_phase = (m_phase + 1) % 256;
            if (send && !m_sendq && !m_busy) begin
                m_busy = 1; m_word = Msg; m_idx = 0; m_ticks = 0;
            end else if (m_busy && ch) begin
                m_ticks++;
                if (m_ticks == BT) begin
                    m_ticks = 0;
                    m_idx++;
                    if (m_idx == MSG_W) m_busy = 0;
                end
            end
            m_sendq = send;
            if (init) begin
                age_h = 0; age_l = 0; m_pl = int'(PL);
            end else begin
                age_h++; age_l++;
            end
        end
    end

    always @(posedge clk) begin : compare
        #2;
        if (chk_en) begin
            check("co_h", co_h, exp_ch());
            check("co_l", co_l, exp_cl());
            check("busy", busy, m_busy);
            check("msg_bit", msg_bit, exp_mb());
            check("magnitude", magnitude, m_mag);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(input bit low, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(low ? co_l : co_h) && n < 2000);
    endtask

    initial begin
        int n, pulses, bitlen, busy_cyc, nb, ones, bad, nonmid;
        int blen [MSG_W];
        bit adv, prev_mb;
        logic [MSG_W-1:0] got;

        rst = 1; init = 0; PL = 3'd0; send = 0; Msg = '0; Mode = 1;
        @(negedge clk);
        chk_en = 1;
        cyc(2);
        check("rst_magnitude", magnitude, 8'h80);
        check("rst_busy", busy, 0);
        check("rst_msg_bit", msg_bit, 0);
        check("rst_co_h", co_h, 0);
        rst = 0;

        wait_pulse(0, n); wait_pulse(0, n);
        check("period_h_pl0", n, 256);
        wait_pulse(1, n); wait_pulse(1, n);
        check("period_l_pl0", n, 512);

        PL = 3'd7; init = 1;
        @(negedge clk);
        init = 0;
        wait_pulse(0, n); wait_pulse(0, n);
        check("period_h_pl7", n, 32);
        wait_pulse(1, n); wait_pulse(1, n);
        check("period_l_pl7", n, 64);

        wait_pulse(0, n);
        cyc(10);
        init = 1;
        @(negedge clk);
        init = 0;
        n = 1;
        while (!co_h && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("init_to_tick", n, 32);

        rst = 1; cyc(2); rst = 0;
        for (int i = 1; i <= 256; i++) begin
            wait_pulse(0, n);
            if (i == 64 || i == 192 || i == 256) begin
                cyc(2);
                check($sformatf("table_after_%0d", i), magnitude,
                      (i == 64) ? 255 : (i == 192) ? 1 : 128);
            end
        end

        Msg = 5'b10110; Mode = 1; send = 1;
        @(negedge clk);
        send = 0;
        @(negedge clk);
        check("fsk_start_busy", busy, 1);
        got = '0;
        got[MSG_W-1] = msg_bit;
        nb = 1; pulses = 0; bitlen = 1; busy_cyc = 1;
        while (busy && busy_cyc < 2000) begin
            adv = co_h && ((pulses + 1) % BT == 0);
            if (co_h) pulses++;
            send = (busy_cyc == 200);
            @(negedge clk);
            busy_cyc++;
            if (adv && busy && nb < MSG_W) begin
                blen[nb-1] = bitlen;
                got[MSG_W-1-nb] = msg_bit;
                nb++;
                bitlen = 1;
            end else begin
                bitlen++;
            end
        end
        send = 0;
        check("fsk_bits", got, 5'b10110);
        check("fsk_nbits", nb, MSG_W);
        for (int i = 1; i < MSG_W - 1; i++)
            check($sformatf("fsk_bit%0d_len", i), blen[i], 128);
        check("fsk_last_len", bitlen - 1, 128);
        check("fsk_frame_len",
              (busy_cyc - 1 > 512) && (busy_cyc - 1 <= 640), 1);

        send = 1;
        @(negedge clk);
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        cyc(50);
        check("held_no_retrigger", busy, 0);
        send = 0;
        @(negedge clk);
        send = 1;
        @(negedge clk);
        check("fresh_edge_starts", busy, 1);
        send = 0;
        cyc(50);
        rst = 1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_msg_bit", msg_bit, 0);
        check("midrst_magnitude", magnitude, 8'h80);
        rst = 0;
        cyc(5);

        Mode = 0; Msg = 5'b01000; send = 1;
        @(negedge clk);
        send = 0;
        ones = 0; bad = 0; nonmid = 0; prev_mb = 0; n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            if (msg_bit) ones++;
            if (magnitude != 8'h80) nonmid++;
            if (!msg_bit && !prev_mb && magnitude != 8'h80) bad++;
            prev_mb = msg_bit;
            @(negedge clk);
            n++;
        end
        check("ook_one_cycles", ones, 128);
        check("ook_mid_when_zero", bad, 0);
        check("ook_tone_seen", nonmid > 0, 1);
        cyc(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
